// File: rtl/gun_shot_sequencer.sv
// Light-gun shot controller: synchronises and debounces the trigger, then runs one
// black frame and one target frame, sampling the photodetector to produce a hit/miss verdict.
module gun_shot_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES  = 65000,
  parameter int unsigned MIN_LIGHT_CYCLES = 1024,
  parameter int unsigned CNT_W            = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic armed,
  input  logic gun_trigger,
  input  logic gun_photodetector,
  output logic blank_screen,
  output logic show_target,
  output logic busy,
  output logic shot_done,
  output logic hit
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    DARK    = 3'd2,
    LIGHT   = 3'd3,
    VERDICT = 3'd4,
    RELEASE = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIGHT_MIN = CNT_W'(MIN_LIGHT_CYCLES);

  logic             trg_m, trg_s, pd_m, pd_s;
  logic             trg_db, trg_db_q;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] light_cnt;
  logic [CNT_W-1:0] light_inc;
  logic             light_enough;
  logic             dark_fail;
  logic             shot_req;
  state_t           state;

  // Two-flop synchronisers for the asynchronous gun inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      trg_m <= 1'b0;
      trg_s <= 1'b0;
      pd_m  <= 1'b0;
      pd_s  <= 1'b0;
    end else begin
      trg_m <= gun_trigger;
      trg_s <= trg_m;
      pd_m  <= gun_photodetector;
      pd_s  <= pd_m;
    end
  end

  // Debounce: accept a new trigger level only after it has held for DEBOUNCE_CYCLES
  always_ff @(posedge clk) begin
    if (rst) begin
      trg_db   <= 1'b0;
      trg_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      trg_db_q <= trg_db;
      if (trg_s != trg_db) begin
        if (db_cnt == DB_LAST) begin
          trg_db <= trg_s;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign shot_req     = trg_db & ~trg_db_q;
  assign light_enough = (light_cnt >= LIGHT_MIN);
  assign light_inc    = light_enough ? light_cnt : light_cnt + CNT_W'(1);

  // Shot sequencer; outputs are registered alongside the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      light_cnt    <= '0;
      dark_fail    <= 1'b0;
      blank_screen <= 1'b0;
      show_target  <= 1'b0;
      busy         <= 1'b0;
      shot_done    <= 1'b0;
      hit          <= 1'b0;
    end else begin
      shot_done <= 1'b0;
      hit       <= 1'b0;
      case (state)
        IDLE: begin
          if (shot_req && armed) begin
            state        <= ARM;
            blank_screen <= 1'b1;
            busy         <= 1'b1;
            light_cnt    <= '0;
            dark_fail    <= 1'b0;
          end
        end
        ARM: begin
          if (frame_start) state <= DARK;
        end
        DARK: begin
          // The boundary cycle itself is not sampled for either frame
          if (frame_start) begin
            dark_fail    <= light_enough;
            light_cnt    <= '0;
            blank_screen <= 1'b0;
            show_target  <= 1'b1;
            state        <= LIGHT;
          end else if (pd_s) begin
            light_cnt <= light_inc;
          end
        end
        LIGHT: begin
          if (frame_start) begin
            show_target <= 1'b0;
            shot_done   <= 1'b1;
            hit         <= ~dark_fail & light_enough;
            state       <= VERDICT;
          end else if (pd_s) begin
            light_cnt <= light_inc;
          end
        end
        VERDICT: begin
          busy  <= 1'b0;
          state <= RELEASE;
        end
        RELEASE: begin
          if (!trg_db) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
